// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_BYTES         = 4;
    localparam int FETCH_DATA_WIDTH    = 32;
    localparam int FETCH_ADDRESS_WIDTH = 16;

    // Default prefetch entry; modules with other widths declare their own
    // entry type and hand it to the FIFO as a type parameter.
    typedef struct packed {
        logic [FETCH_ADDRESS_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode handshakes of the fetch unit.
interface fetch_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
);

    logic                     imem_req;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_gnt;
    logic                     imem_rvalid;
    logic [DATA_WIDTH-1:0]    imem_rdata;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     instr_valid;
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Pointer-based synchronous prefetch FIFO with flush; head reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    parameter int  CW      = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output entry_t        head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;
    entry_t        mem [DEPTH];

    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the empty gating on head hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: credit-limited request issue, in-order
// response capture into a prefetch FIFO, and redirect with in-flight drop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int                       CW        = cnt_width(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(INSTR_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN     = ~ADDRESS_WIDTH'(3);
    localparam logic [CW:0]              DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] resp_pc;
    logic [ADDRESS_WIDTH-1:0] redirect_base;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            drop_cnt;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     grant;
    logic                     push;
    logic                     drop;
    logic                     pop;
    entry_t                   head;
    entry_t                   wdata;

    // Credit check counts both buffered and in-flight words, so a response
    // always has a free slot waiting and rvalid never needs back-pressure.
    assign bus.imem_req  = rst && (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_LIM)
                           && !bus.redirect_valid;
    assign bus.imem_addr = fetch_pc;
    assign grant         = bus.imem_req && bus.imem_gnt;
    assign redirect_base = bus.redirect_pc & ALIGN;

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign pop             = bus.instr_valid && bus.instr_ready;
    assign wdata           = '{pc: resp_pc, instr: bus.imem_rdata};

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        push = 1'b0;
        drop = 1'b0;
        if (bus.imem_rvalid && !bus.redirect_valid) begin
            if (drop_cnt != '0) drop = 1'b1;
            else                push = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(bus.imem_rvalid);
            if (bus.redirect_valid) begin
                // Everything still in flight belongs to the old stream.
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                drop_cnt <= outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (grant) fetch_pc <= fetch_pc + STEP;
                if (push)  resp_pc  <= resp_pc + STEP;
                if (drop)  drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata (wdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (head)
    );

    a_rvalid_has_credit: assert property (
        @(posedge clk) disable iff (!rst) !(bus.imem_rvalid && outstanding == '0));

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction-memory model of
// programmable response latency.
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 1;
    int   cyc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;
    pend_t pend_q[$];

    fetch_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    fetch_unit #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .FIFO_DEPTH    (4),
        .RESET_PC      (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {16'h0000, a};
    endfunction

    // Memory: grants sampled just before the rising edge, responses driven
    // 1ns after an edge so they are sampled at the following edge.
    initial begin
        pend_t p;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                pend_q.delete();
            end else if (bus.imem_req && bus.imem_gnt) begin
                p.addr = bus.imem_addr;
                p.due  = cyc + mem_lat;
                pend_q.push_back(p);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_at(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
                if (!rst) pend_q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input int lat, input logic ready);
        @(negedge clk);
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b1;
        bus.instr_ready    = ready;
        mem_lat            = lat;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
        checks++; if (bus.instr_pc !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.instr_pc); end
    endtask

    task automatic test_stream();
        logic [AW-1:0] exp_pc;
        do_reset(1, 1'b1);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stream_req0: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0) begin errors++; $display("FAIL stream_addr0: got %h expected 0000", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0: got %b expected 0", bus.instr_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.imem_addr !== AW'(4 * (k + 1))) begin errors++; $display("FAIL stream_addr k=%0d: got %h expected %h", k, bus.imem_addr, AW'(4 * (k + 1))); end
            if (k == 0) begin
                checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: instr_valid %b expected 0 one cycle after grant", bus.instr_valid); end
            end else begin
                exp_pc = AW'(4 * (k - 1));
                checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d: got %b expected 1", k, bus.instr_valid); end
                checks++; if (bus.instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc k=%0d: got %h expected %h", k, bus.instr_pc, exp_pc); end
                checks++; if (bus.instr !== word_at(exp_pc)) begin errors++; $display("FAIL stream_instr k=%0d: got %h expected %h", k, bus.instr, word_at(exp_pc)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        logic [AW-1:0] exp_pc;
        do_reset(1, 1'b0);
        repeat (10) begin
            if (bus.imem_req && bus.imem_gnt) grants++;
            @(negedge clk);
            #1;
        end
        checks++; if (grants !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", grants); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %b expected 0", bus.imem_req); end
        checks++; if (bus.instr_pc !== 16'h0) begin errors++; $display("FAIL bp_head: got %h expected 0000", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            exp_pc = AW'(4 * (i + 1));
            if (i == 0) begin
                checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010) begin errors++; $display("FAIL bp_resume: req %b addr %h expected 1 0010", bus.imem_req, bus.imem_addr); end
            end
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc) begin errors++; $display("FAIL bp_drain i=%0d: valid %b pc %h expected 1 %h", i, bus.instr_valid, bus.instr_pc, exp_pc); end
            checks++; if (bus.instr !== word_at(exp_pc)) begin errors++; $display("FAIL bp_data i=%0d: got %h expected %h", i, bus.instr, word_at(exp_pc)); end
        end
    endtask

    task automatic test_gnt_stall();
        do_reset(1, 1'b1);
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0) begin errors++; $display("FAIL stall_hold i=%0d: req %b addr %h expected 1 0000", i, bus.imem_req, bus.imem_addr); end
            @(negedge clk);
            #1;
        end
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.imem_addr !== 16'h0004) begin errors++; $display("FAIL stall_advance: got %h expected 0004", bus.imem_addr); end
        @(negedge clk);
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== word_at(16'h0)) begin
            errors++; $display("FAIL stall_first: valid %b pc %h instr %h expected 1 0000 %h", bus.instr_valid, bus.instr_pc, bus.instr, word_at(16'h0));
        end
    endtask

    // Waits for the first presented instruction and requires it to be exp_pc.
    task automatic expect_first(input string name, input logic [AW-1:0] exp_pc);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.instr_valid) begin
                seen = 1;
                checks++; if (bus.instr_pc !== exp_pc || bus.instr !== word_at(exp_pc)) begin
                    errors++; $display("FAIL %s_first: pc %h instr %h expected %h %h", name, bus.instr_pc, bus.instr, exp_pc, word_at(exp_pc));
                end
            end
        end
        if (!seen) begin
            checks++; errors++; $display("FAIL %s_timeout: no instruction within 12 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(3, 1'b1);
        repeat (2) begin @(negedge clk); #1; end
        checks++; if (bus.imem_rvalid !== 1'b0 || bus.imem_addr !== 16'h0008) begin errors++; $display("FAIL redir_pre: rvalid %b addr %h expected 0 0008", bus.imem_rvalid, bus.imem_addr); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0102;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_blocked: got %b expected 0", bus.imem_req); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_empty: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin errors++; $display("FAIL redir_addr: req %b addr %h expected 1 0100", bus.imem_req, bus.imem_addr); end
        expect_first("redir", 16'h0100);
    endtask

    task automatic test_redirect_rvalid_pop();
        do_reset(2, 1'b1);
        repeat (4) begin @(negedge clk); #1; end
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0004 || bus.imem_rvalid !== 1'b1) begin
            errors++; $display("FAIL rrp_pre: valid %b pc %h rvalid %b expected 1 0004 1", bus.instr_valid, bus.instr_pc, bus.imem_rvalid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0200;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rrp_empty: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0200) begin errors++; $display("FAIL rrp_addr: req %b addr %h expected 1 0200", bus.imem_req, bus.imem_addr); end
        expect_first("rrp", 16'h0200);
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b1);
        repeat (3) begin @(negedge clk); #1; end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFE;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 16'hFFFC) begin errors++; $display("FAIL wrap_align: got %h expected FFFC", bus.imem_addr); end
        @(negedge clk);
        #1;
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", bus.imem_addr); end
        expect_first("wrap", 16'hFFFC);
        @(negedge clk);
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.instr !== word_at(16'h0000)) begin
            errors++; $display("FAIL wrap_next: valid %b pc %h instr %h expected 1 0000 %h", bus.instr_valid, bus.instr_pc, bus.instr, word_at(16'h0000));
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1, 1'b0);
        repeat (8) begin @(negedge clk); #1; end
        checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_full: valid %b req %b expected 1 0", bus.instr_valid, bus.imem_req); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_async: valid %b req %b expected 0 0", bus.instr_valid, bus.imem_req); end
        checks++; if (bus.instr !== 32'h0 || bus.instr_pc !== 16'h0) begin errors++; $display("FAIL mid_outputs: instr %h pc %h expected 0 0", bus.instr, bus.instr_pc); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL mid_restart: req %b addr %h expected 1 0000", bus.imem_req, bus.imem_addr); end
        repeat (2) begin @(negedge clk); #1; end
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== word_at(16'h0)) begin
            errors++; $display("FAIL mid_first: valid %b pc %h instr %h expected 1 0000 %h", bus.instr_valid, bus.instr_pc, bus.instr, word_at(16'h0));
        end
    endtask

    initial begin
        bus.imem_gnt       = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_drop();
        test_redirect_rvalid_pop();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the RV32I core. Replaces the single-cycle PC register plus combinational instruction-memory lookup.
- Issues word fetches to an instruction memory with a request/grant handshake and in-order responses.
- Buffers returned instructions with their PCs in a prefetch FIFO and presents them to decode through a valid/ready handshake.
- Accepts branch/jump redirects: flushes the FIFO and discards responses still in flight.

Parameters:
- DATA_WIDTH, 32, instruction width in bits.
- ADDRESS_WIDTH, 16, byte-address width of the PC and the memory address.
- FIFO_DEPTH, 4, prefetch entries. Power of two, at least 2.
- RESET_PC, 0, fetch address after reset. Must be word-aligned.

Ports:
- clk  in  1  core clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDRESS_WIDTH  fetch byte address. Bits [1:0] are always 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  DATA_WIDTH  instruction word.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  ADDRESS_WIDTH  new fetch address.
- instr_valid  out  1  FIFO head valid.
- instr  out  DATA_WIDTH  head instruction.
- instr_pc  out  ADDRESS_WIDTH  head PC.
- instr_ready  in  1  decode accepts the head.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - FIFO empty.
  - outstanding = 0, drop_cnt = 0.
  - imem_req = 0, instr_valid = 0; instr and instr_pc = 0.
- First request may be asserted in the first cycle after rst deasserts.
- Credit rule:
  - imem_req = (count + outstanding < FIFO_DEPTH) && !redirect_valid.
  - This guarantees the FIFO never overflows; no response is ever back-pressured.
- Request handshake:
  - imem_addr = fetch_pc.
  - Accepted when imem_req && imem_gnt; then fetch_pc += 4 (wraps modulo 2^ADDRESS_WIDTH) and outstanding increments.
  - While imem_req && !imem_gnt, imem_addr holds stable. The only exception is a redirect.
- Response handling:
  - Responses are in order, one per accepted request, arriving no earlier than the cycle after the grant.
  - Each imem_rvalid decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {resp_pc, imem_rdata} is pushed into the FIFO and resp_pc += 4.
- Output:
  - instr_valid = FIFO not empty; instr and instr_pc show the FIFO head.
  - Pop when instr_valid && instr_ready.
  - No bypass. Best-case latency: grant at cycle N, rvalid at N+1, instr_valid at N+2.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (redirect_valid = 1), highest priority:
  - FIFO cleared; any pop or push in that cycle is ignored.
  - fetch_pc and resp_pc take {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
  - imem_req is forced 0 that cycle, which abandons any pending ungranted request.
  - drop_cnt = outstanding, minus 1 if imem_rvalid is high in the same cycle.
  - Fetch resumes the next cycle.
- Redirect while drop_cnt > 0: drop_cnt is recomputed by the same formula. The FIFO stays clean.
- Reset mid-operation: all state returns to reset values immediately. The memory side is reset together with the core, so no stale responses arrive.
- Assertions:
  - imem_rvalid with outstanding == 0 is an error.
  - A FIFO push while full is an error.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_BYTES = 4.
  - Typedef fetch_entry_t (struct {pc, instr}), widths taken from the parameters via a localparam-sized packed struct.
  - Counter width function clog2(FIFO_DEPTH+1).
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, empty, full, head.
  - Pointer-based, wraps at FIFO_DEPTH.
- fetch_unit itself holds the PC, outstanding and drop counters, and the handshake logic.

Test Plan:
- Reset release, imem_gnt tied 1, rvalid one cycle after grant, instr_ready = 1 -> imem_addr 0x0, 0x4, 0x8…; instr_valid first high 2 cycles after the first grant; instr_pc 0x0, 0x4, 0x8 in order with the matching data.
- instr_ready = 0, FIFO_DEPTH = 4 -> exactly 4 grants, then imem_req stays 0; count = 4. Raising ready resumes requests one per pop.
- imem_gnt low for 3 cycles -> imem_req high and imem_addr stable at the same value for 3 cycles; fetch_pc advances only on the grant.
- Redirect to 0x0102 with 2 requests outstanding -> next request addr 0x0100; the 2 in-flight responses are dropped; the first instr_pc out is 0x0100; FIFO empty the cycle after the redirect.
- Redirect in the same cycle as rvalid and a pop -> the response is dropped, drop_cnt = outstanding - 1, no stale instruction is presented.
- rst asserted mid-stream with a full FIFO -> instr_valid and imem_req drop to 0 immediately; after release the first imem_addr = RESET_PC.
